// File: rtl/graphic_line_sequencer.sv
// graphic_line_sequencer: per-scanline descriptor walker that starts and waits on the graphic units.
// Define GRAPHIC_SEQ_TIMEOUT_EN to add a WAIT_DONE watchdog that sets the sticky timeout_err.
module graphic_line_sequencer #(
  parameter int LINES   = 240,
  parameter int ELEMS   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_start,
  input  logic                     line_ready,
  output logic [$clog2(ELEMS)-1:0] desc_addr,
  input  logic [31:0]              desc_data,
  output logic [$clog2(ELEMS)-1:0] elem_index,
  output logic [11:0]              dy,
  output logic [3:0]               unit_start,
  input  logic [3:0]               unit_done,
  output logic                     line_done,
  output logic                     frame_done,
  output logic                     busy,
  output logic                     timeout_err
);
  localparam int AW = $clog2(ELEMS);
  localparam logic [AW-1:0] LAST_ELEM = AW'(ELEMS - 1);
  localparam logic [11:0]   LAST_LINE = 12'(LINES - 1);

  // state     | meaning
  // IDLE      | no frame in progress, waiting for frame_start
  // WAIT_LINE | waiting for the line buffer to accept a line
  // FETCH     | desc_addr presented for element e
  // CHECK     | descriptor returned, coverage of dy tested
  // START     | one-cycle unit_start to the owning unit
  // WAIT_DONE | waiting for unit_done of that unit
  // END_LINE  | line_done (and frame_done on the last line)
  typedef enum logic [2:0] {
    IDLE, WAIT_LINE, FETCH, CHECK, START, WAIT_DONE, END_LINE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] elem_q, elem_d, index_q, index_d;
  logic [11:0]   dy_q, dy_d;
  logic [1:0]    uid_q, uid_d;
  logic [3:0]    start_q, start_d;
  logic          line_done_q, line_done_d, frame_done_q, frame_done_d;
  logic          busy_q, busy_d;
  logic          advance, hit;
  logic [12:0]   y_end;
  logic          unused_rsvd;

`ifdef GRAPHIC_SEQ_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        terr_q, terr_d;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  // 13-bit end so a region running past line 4095 cannot wrap into a hit
  assign y_end       = {1'b0, desc_data[28:17]} + {1'b0, desc_data[16:5]};
  assign hit         = desc_data[31] && (dy_q >= desc_data[28:17]) && ({1'b0, dy_q} < y_end);
  assign unused_rsvd = ^desc_data[4:0];

  always_comb begin
    state_d      = state_q;
    elem_d       = elem_q;
    index_d      = index_q;
    dy_d         = dy_q;
    uid_d        = uid_q;
    start_d      = 4'b0000;
    line_done_d  = 1'b0;
    frame_done_d = 1'b0;
    advance      = 1'b0;
`ifdef GRAPHIC_SEQ_TIMEOUT_EN
    cnt_d        = cnt_q;
    terr_d       = terr_q;
`endif
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          dy_d    = 12'd0;
          state_d = WAIT_LINE;
`ifdef GRAPHIC_SEQ_TIMEOUT_EN
          terr_d  = 1'b0;
`endif
        end
      end
      WAIT_LINE: begin
        if (line_ready) begin
          elem_d  = '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = CHECK;
      CHECK: begin
        uid_d = desc_data[30:29];
        if (hit) begin
          start_d = 4'b0001 << desc_data[30:29];
          index_d = elem_q;
          state_d = START;
        end else begin
          advance = 1'b1;
        end
      end
      START: begin
        state_d = WAIT_DONE;
`ifdef GRAPHIC_SEQ_TIMEOUT_EN
        cnt_d   = 16'(TIMEOUT - 1);
`endif
      end
      WAIT_DONE: begin
        if (unit_done[uid_q]) begin
          advance = 1'b1;
        end
`ifdef GRAPHIC_SEQ_TIMEOUT_EN
        else if (cnt_q == 16'd0) begin
          terr_d  = 1'b1;
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
`endif
      end
      END_LINE: begin
        if (dy_q == LAST_LINE) begin
          dy_d    = 12'd0;
          state_d = IDLE;
        end else begin
          dy_d    = dy_q + 12'd1;
          state_d = WAIT_LINE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (elem_q == LAST_ELEM) begin
        state_d      = END_LINE;
        line_done_d  = 1'b1;
        frame_done_d = (dy_q == LAST_LINE);
      end else begin
        elem_d  = elem_q + AW'(1);
        state_d = FETCH;
      end
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      elem_q       <= '0;
      index_q      <= '0;
      dy_q         <= 12'd0;
      uid_q        <= 2'd0;
      start_q      <= 4'b0000;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      elem_q       <= elem_d;
      index_q      <= index_d;
      dy_q         <= dy_d;
      uid_q        <= uid_d;
      start_q      <= start_d;
      line_done_q  <= line_done_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

`ifdef GRAPHIC_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= 16'd0;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      terr_q <= terr_d;
    end
  end
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign desc_addr  = elem_q;
  assign elem_index = index_q;
  assign dy         = dy_q;
  assign unit_start = start_q;
  assign line_done  = line_done_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
endmodule
